div_ratio_detector: RTL and testbench

- Receive-side companion to the even clock dividers: measures a divided-clock waveform sampled in the clk domain.
- Reports its period, high time and lock status; flags a clean even ratio with 50% duty.
- Used by self-checks and clock-monitor logic to confirm that div2/div4/div6-style outputs have the expected ratio.
- Input is already synchronous to clk; there is no CDC inside.

---
 rtl/div_ratio_detector.sv | 157 +++++++++++++++
 tb/tb_div_ratio_detector.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ratio_detector.sv
// ---------------------------------------------------------------------------
// div_ratio_detector
//
// Measures a divided-clock waveform that is already synchronous to clk.
// Reports the rise-to-rise period and the high time within that period,
// asserts locked once LOCK_CNT consecutive identical measurements have been
// seen, and flags even_50 for a locked, even-ratio, 50%-duty waveform.
//
// Ports
//   clk        : clock
//   resetn     : synchronous active-low reset
//   sig_in     : divided waveform, sampled every clk cycle
//   period     : last measured period in clk cycles (rise to rise)
//   high_time  : cycles sig_in was 1 within that period
//   meas_valid : one-cycle pulse, period/high_time updated this cycle
//   locked     : LOCK_CNT consecutive identical measurements seen
//   even_50    : locked, even period, high_time == period/2
//   overflow   : no rise within 2^CNT_W-1 cycles; held until next meas_valid
// ---------------------------------------------------------------------------
module div_ratio_detector #(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             even_50,
    output logic             overflow
);

    typedef enum logic [1:0] {
        WAIT_LOW  = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);

    state_t           state_q;
    logic             sig_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] hi_cnt_q;
    // Captured measurement waiting one cycle before it is published.
    logic             pend_q;
    logic [CNT_W-1:0] cap_per_q;
    logic [CNT_W-1:0] cap_hi_q;
    logic [3:0]       match_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] high_q;
    logic             meas_valid_q;
    logic             locked_q;
    logic             even_q;
    logic             overflow_q;

    logic             rise;
    logic             same;
    logic [3:0]       match_d;
    logic             locked_d;
    logic             even_d;

    // Lock bookkeeping for the pending measurement, compared against the
    // currently published one. match_q==0 marks "no previous measurement".
    always_comb begin
        rise     = sig_in & ~sig_q;
        same     = (cap_per_q == period_q) && (cap_hi_q == high_q);
        match_d  = 4'd1;
        if (match_q != 4'd0 && same) begin
            if (match_q < LOCK_TGT) match_d = match_q + 4'd1;
            else                    match_d = match_q;
        end
        locked_d = (match_d >= LOCK_TGT);
        even_d   = locked_d & ~cap_per_q[0] & (cap_hi_q == (cap_per_q >> 1));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= WAIT_LOW;
            sig_q        <= 1'b0;
            cnt_q        <= '0;
            hi_cnt_q     <= '0;
            pend_q       <= 1'b0;
            cap_per_q    <= '0;
            cap_hi_q     <= '0;
            match_q      <= 4'd0;
            period_q     <= '0;
            high_q       <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            even_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            sig_q        <= sig_in;
            meas_valid_q <= pend_q;
            pend_q       <= 1'b0;

            if (pend_q) begin
                period_q   <= cap_per_q;
                high_q     <= cap_hi_q;
                match_q    <= match_d;
                locked_q   <= locked_d;
                even_q     <= even_d;
                overflow_q <= 1'b0;
            end

            case (state_q)
                // Wait for a low sample so a high level at reset release
                // is not mistaken for a rising edge.
                WAIT_LOW: begin
                    if (!sig_in) state_q <= WAIT_RISE;
                end
                WAIT_RISE: begin
                    if (rise) begin
                        cnt_q    <= CNT_ONE;
                        hi_cnt_q <= CNT_ONE;
                        state_q  <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        // A rise at cnt==max still counts as a measurement.
                        cap_per_q <= cnt_q;
                        cap_hi_q  <= hi_cnt_q;
                        pend_q    <= 1'b1;
                        cnt_q     <= CNT_ONE;
                        hi_cnt_q  <= CNT_ONE;
                    end else if (cnt_q == CNT_MAX) begin
                        overflow_q <= 1'b1;
                        locked_q   <= 1'b0;
                        even_q     <= 1'b0;
                        match_q    <= 4'd0;
                        cnt_q      <= '0;
                        hi_cnt_q   <= '0;
                        state_q    <= WAIT_LOW;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                        if (sig_in) hi_cnt_q <= hi_cnt_q + CNT_ONE;
                    end
                end
                default: state_q <= WAIT_LOW;
            endcase
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign even_50    = even_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_div_ratio_detector.sv
module tb_div_ratio_detector;

    localparam int LOCK = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT a: CNT_W=8, DUT b: CNT_W=4 (overflow scenarios)
    logic       rst_a = 1'b0, sig_a = 1'b0;
    logic       rst_b = 1'b0, sig_b = 1'b0;
    logic [7:0] per_a, hi_a;
    logic       mv_a, lk_a, ev_a, ov_a;
    logic [3:0] per_b, hi_b;
    logic       mv_b, lk_b, ev_b, ov_b;

    div_ratio_detector #(.CNT_W(8), .LOCK_CNT(LOCK)) u_dut_a (
        .clk(clk), .resetn(rst_a), .sig_in(sig_a),
        .period(per_a), .high_time(hi_a), .meas_valid(mv_a),
        .locked(lk_a), .even_50(ev_a), .overflow(ov_a));

    div_ratio_detector #(.CNT_W(4), .LOCK_CNT(LOCK)) u_dut_b (
        .clk(clk), .resetn(rst_b), .sig_in(sig_b),
        .period(per_b), .high_time(hi_b), .meas_valid(mv_b),
        .locked(lk_b), .even_50(ev_b), .overflow(ov_b));

    int n_checks = 0;
    int n_fail   = 0;
    int cycn     = 0;

    // ---------------- reference model (timestamp based) ----------------
    // A period is the distance between two rise timestamps; high time is the
    // count of 1 samples from the reference rise up to the next rise. Lock is
    // the length of the trailing run of identical measurements.
    bit m_armed[2], m_track[2], m_prev[2], m_pend[2];
    int m_rt[2], m_ones[2], m_pp[2], m_ph[2];
    int m_run[2], m_lp[2], m_lh[2];
    bit e_mv[2], e_lk[2], e_ev[2], e_ov[2];
    int e_per[2], e_hi[2];

    task automatic model_step(input int d, input logic s, input logic r);
        int  maxv;
        bit  rise;
        maxv = (d == 0) ? 255 : 15;
        if (!r) begin
            m_armed[d] = 0; m_track[d] = 0; m_prev[d] = 0; m_pend[d] = 0;
            m_run[d] = 0;
            e_mv[d] = 0; e_lk[d] = 0; e_ev[d] = 0; e_ov[d] = 0;
            e_per[d] = 0; e_hi[d] = 0;
            return;
        end
        e_mv[d] = 0;
        if (m_pend[d]) begin
            m_pend[d] = 0;
            e_mv[d] = 1; e_per[d] = m_pp[d]; e_hi[d] = m_ph[d]; e_ov[d] = 0;
            if (m_run[d] > 0 && m_pp[d] == m_lp[d] && m_ph[d] == m_lh[d]) m_run[d]++;
            else m_run[d] = 1;
            m_lp[d] = m_pp[d]; m_lh[d] = m_ph[d];
            e_lk[d] = (m_run[d] >= LOCK);
            e_ev[d] = e_lk[d] && (m_pp[d] % 2 == 0) && (2 * m_ph[d] == m_pp[d]);
        end
        rise = s && !m_prev[d];
        if (!m_armed[d]) begin
            if (!s) m_armed[d] = 1;
        end else if (!m_track[d]) begin
            if (rise) begin m_track[d] = 1; m_rt[d] = cycn; m_ones[d] = 1; end
        end else if (rise) begin
            m_pend[d] = 1; m_pp[d] = cycn - m_rt[d]; m_ph[d] = m_ones[d];
            m_rt[d] = cycn; m_ones[d] = 1;
        end else if (cycn - m_rt[d] == maxv) begin
            e_ov[d] = 1; e_lk[d] = 0; e_ev[d] = 0; m_run[d] = 0;
            m_track[d] = 0; m_armed[d] = 0;
        end else begin
            m_ones[d] += int'(s);
        end
        m_prev[d] = s;
    endtask

    function automatic logic [19:0] exp_a();
        logic [7:0] p, h;
        p = e_per[0][7:0]; h = e_hi[0][7:0];
        return {e_mv[0], p, h, e_lk[0], e_ev[0], e_ov[0]};
    endfunction

    function automatic logic [11:0] exp_b();
        logic [3:0] p, h;
        p = e_per[1][3:0]; h = e_hi[1][3:0];
        return {e_mv[1], p, h, e_lk[1], e_ev[1], e_ov[1]};
    endfunction

    // Inputs are set #1 after a posedge; model steps on the values sampled.
    task automatic tick();
        @(posedge clk);
        model_step(0, sig_a, rst_a);
        model_step(1, sig_b, rst_b);
        cycn++;
        #1;
    endtask

    // ---------------------------------------------------------------
    task automatic test_reset();
        rst_a = 0; rst_b = 0; sig_a = 1; sig_b = 1;
        repeat (3) tick();
        n_checks++;
        if ({mv_a, per_a, hi_a, lk_a, ev_a, ov_a} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_a: got %h want 0", {mv_a, per_a, hi_a, lk_a, ev_a, ov_a});
        end
        n_checks++;
        if ({mv_b, per_b, hi_b, lk_b, ev_b, ov_b} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_b: got %h want 0", {mv_b, per_b, hi_b, lk_b, ev_b, ov_b});
        end
    endtask

    // Release with sig high, then div4.
    task automatic test_release_high();
        logic [3:0] pat;
        pat = 4'b0110;  // bit i = sample i: 0,1,1,0
        rst_a = 1; sig_a = 1;
        repeat (3) begin
            tick();
            n_checks++;
            if (mv_a !== 1'b0) begin n_fail++; $display("FAIL rel_early_mv: got %b want 0", mv_a); end
        end
        for (int g = 0; g < 16; g++) begin
            sig_a = pat[g % 4];
            tick();
            n_checks++;
            if ({mv_a, per_a, hi_a, lk_a, ev_a, ov_a} !== exp_a()) begin
                n_fail++; $display("FAIL rel_model g=%0d: got %h want %h", g, {mv_a, per_a, hi_a, lk_a, ev_a, ov_a}, exp_a());
            end
            n_checks++;
            if (mv_a !== ((g == 6) || (g == 10) || (g == 14))) begin
                n_fail++; $display("FAIL rel_mv_time g=%0d: got %b", g, mv_a);
            end
            if (g == 6) begin
                n_checks++;
                if ({per_a, hi_a, lk_a, ev_a} !== {8'd4, 8'd2, 1'b0, 1'b0}) begin
                    n_fail++; $display("FAIL rel_first: got per=%0d hi=%0d lk=%b ev=%b want 4 2 0 0", per_a, hi_a, lk_a, ev_a);
                end
            end
            if (g == 10) begin
                n_checks++;
                if ({per_a, hi_a, lk_a, ev_a} !== {8'd4, 8'd2, 1'b1, 1'b1}) begin
                    n_fail++; $display("FAIL rel_second: got per=%0d hi=%0d lk=%b ev=%b want 4 2 1 1", per_a, hi_a, lk_a, ev_a);
                end
            end
        end
    endtask

    task automatic test_div2();
        rst_a = 0; sig_a = 0; tick(); rst_a = 1;
        for (int g = 0; g < 14; g++) begin
            sig_a = g[0];
            tick();
            n_checks++;
            if ({mv_a, per_a, hi_a, lk_a, ev_a, ov_a} !== exp_a()) begin
                n_fail++; $display("FAIL div2_model g=%0d: got %h want %h", g, {mv_a, per_a, hi_a, lk_a, ev_a, ov_a}, exp_a());
            end
            n_checks++;
            if (mv_a !== (g >= 4 && g % 2 == 0)) begin
                n_fail++; $display("FAIL div2_mv g=%0d: got %b", g, mv_a);
            end
            if (mv_a) begin
                n_checks++;
                if ({per_a, hi_a, lk_a, ev_a} !== {8'd2, 8'd1, (g >= 6), (g >= 6)}) begin
                    n_fail++; $display("FAIL div2_meas g=%0d: got per=%0d hi=%0d lk=%b ev=%b", g, per_a, hi_a, lk_a, ev_a);
                end
            end
        end
    endtask

    task automatic test_div6_to_div4();
        logic [5:0] p6;
        logic [3:0] p4;
        int mc;
        p6 = 6'b001110; p4 = 4'b0110; mc = 0;
        rst_a = 0; sig_a = 0; tick(); rst_a = 1;
        for (int g = 0; g < 40; g++) begin
            sig_a = (g < 24) ? p6[g % 6] : p4[(g - 24) % 4];
            tick();
            n_checks++;
            if ({mv_a, per_a, hi_a, lk_a, ev_a, ov_a} !== exp_a()) begin
                n_fail++; $display("FAIL d64_model g=%0d: got %h want %h", g, {mv_a, per_a, hi_a, lk_a, ev_a, ov_a}, exp_a());
            end
            if (mv_a) begin
                mc++;
                n_checks++;
                if (mc <= 4) begin
                    if ({per_a, hi_a, lk_a, ev_a} !== {8'd6, 8'd3, (mc >= 2), (mc >= 2)}) begin
                        n_fail++; $display("FAIL d64_div6 m=%0d: got per=%0d hi=%0d lk=%b ev=%b", mc, per_a, hi_a, lk_a, ev_a);
                    end
                end else if (mc == 5) begin
                    if ({per_a, hi_a, lk_a, ev_a} !== {8'd4, 8'd2, 1'b0, 1'b0}) begin
                        n_fail++; $display("FAIL d64_switch: got per=%0d hi=%0d lk=%b ev=%b want 4 2 0 0", per_a, hi_a, lk_a, ev_a);
                    end
                end else if ({per_a, hi_a, lk_a, ev_a} !== {8'd4, 8'd2, 1'b1, 1'b1}) begin
                    n_fail++; $display("FAIL d64_relock m=%0d: got per=%0d hi=%0d lk=%b ev=%b", mc, per_a, hi_a, lk_a, ev_a);
                end
            end
        end
        n_checks++;
        if (mc !== 7) begin n_fail++; $display("FAIL d64_count: got %0d want 7", mc); end
    endtask

    task automatic test_non50();
        logic [4:0] p5;
        int mc;
        p5 = 5'b11000; mc = 0;  // 0,0,0,1,1
        rst_a = 0; sig_a = 0; tick(); rst_a = 1;
        for (int g = 0; g < 25; g++) begin
            sig_a = p5[g % 5];
            tick();
            n_checks++;
            if ({mv_a, per_a, hi_a, lk_a, ev_a, ov_a} !== exp_a()) begin
                n_fail++; $display("FAIL non50_model g=%0d: got %h want %h", g, {mv_a, per_a, hi_a, lk_a, ev_a, ov_a}, exp_a());
            end
            if (mv_a) begin
                mc++;
                n_checks++;
                if ({per_a, hi_a, lk_a, ev_a} !== {8'd5, 8'd2, (mc >= 2), 1'b0}) begin
                    n_fail++; $display("FAIL non50_meas m=%0d: got per=%0d hi=%0d lk=%b ev=%b", mc, per_a, hi_a, lk_a, ev_a);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [3:0] p4;
        p4 = 4'b0110;
        rst_a = 1; sig_a = 0;
        rst_b = 0; sig_b = 0; tick(); rst_b = 1;
        for (int g = 0; g < 48; g++) begin
            sig_b = (g < 16) ? p4[g % 4] : (g < 36) ? 1'b0 : p4[(g - 36) % 4];
            tick();
            n_checks++;
            if ({mv_b, per_b, hi_b, lk_b, ev_b, ov_b} !== exp_b()) begin
                n_fail++; $display("FAIL ovf_model g=%0d: got %h want %h", g, {mv_b, per_b, hi_b, lk_b, ev_b, ov_b}, exp_b());
            end
            n_checks++;
            if (ov_b !== (g >= 28 && g < 42)) begin
                n_fail++; $display("FAIL ovf_flag g=%0d: got %b", g, ov_b);
            end
            if (g == 27) begin
                n_checks++;
                if (lk_b !== 1'b1) begin n_fail++; $display("FAIL ovf_prelock: got %b want 1", lk_b); end
            end
            if (g == 28) begin
                n_checks++;
                if ({per_b, hi_b, lk_b, ev_b} !== {4'd4, 4'd2, 1'b0, 1'b0}) begin
                    n_fail++; $display("FAIL ovf_hold: got per=%0d hi=%0d lk=%b ev=%b want 4 2 0 0", per_b, hi_b, lk_b, ev_b);
                end
            end
            if (g == 42) begin
                n_checks++;
                if ({mv_b, per_b, lk_b} !== {1'b1, 4'd4, 1'b0}) begin
                    n_fail++; $display("FAIL ovf_resume: got mv=%b per=%0d lk=%b want 1 4 0", mv_b, per_b, lk_b);
                end
            end
            if (g == 46) begin
                n_checks++;
                if ({mv_b, lk_b, ev_b} !== 3'b111) begin
                    n_fail++; $display("FAIL ovf_relock: got %b want 111", {mv_b, lk_b, ev_b});
                end
            end
        end
        rst_b = 0; sig_b = 0;
    endtask

    task automatic test_reset_mid();
        logic [5:0] p6;
        int mc;
        p6 = 6'b001110; mc = 0;
        rst_a = 0; sig_a = 0; tick(); rst_a = 1;
        for (int g = 0; g < 21; g++) begin
            sig_a = p6[g % 6];
            tick();
        end
        n_checks++;
        if (lk_a !== 1'b1) begin n_fail++; $display("FAIL rmid_prelock: got %b want 1", lk_a); end
        rst_a = 0; sig_a = 1;
        tick();
        rst_a = 1;
        n_checks++;
        if ({mv_a, per_a, hi_a, lk_a, ev_a, ov_a} !== 20'h0) begin
            n_fail++; $display("FAIL rmid_zero: got %h want 0", {mv_a, per_a, hi_a, lk_a, ev_a, ov_a});
        end
        for (int h = 0; h < 20; h++) begin
            sig_a = p6[(h + 4) % 6];
            tick();
            n_checks++;
            if ({mv_a, per_a, hi_a, lk_a, ev_a, ov_a} !== exp_a()) begin
                n_fail++; $display("FAIL rmid_model h=%0d: got %h want %h", h, {mv_a, per_a, hi_a, lk_a, ev_a, ov_a}, exp_a());
            end
            if (mv_a) begin
                mc++;
                n_checks++;
                if ({per_a, hi_a, lk_a} !== {8'd6, 8'd3, (mc >= 2)}) begin
                    n_fail++; $display("FAIL rmid_meas m=%0d: got per=%0d hi=%0d lk=%b", mc, per_a, hi_a, lk_a);
                end
            end
        end
        n_checks++;
        if (mc !== 2) begin n_fail++; $display("FAIL rmid_count: got %0d want 2", mc); end
    endtask

    task automatic test_random();
        int per, hi, reps, gap;
        rst_a = 0; sig_a = 0; tick(); rst_a = 1;
        for (int k = 0; k < 40; k++) begin
            per  = $urandom_range(2, 14);
            hi   = $urandom_range(1, per - 1);
            reps = $urandom_range(1, 4);
            for (int r = 0; r < reps; r++) begin
                for (int i = 0; i < per; i++) begin
                    sig_a = (i >= per - hi);
                    rst_a = ($urandom_range(0, 199) != 0);
                    tick();
                    n_checks++;
                    if ({mv_a, per_a, hi_a, lk_a, ev_a, ov_a} !== exp_a()) begin
                        n_fail++; $display("FAIL rand_a k=%0d: got %h want %h", k, {mv_a, per_a, hi_a, lk_a, ev_a, ov_a}, exp_a());
                    end
                end
            end
        end
        rst_a = 1; sig_a = 0;
        rst_b = 0; sig_b = 0; tick(); rst_b = 1;
        for (int k = 0; k < 30; k++) begin
            per  = $urandom_range(2, 8);
            hi   = $urandom_range(1, per - 1);
            reps = $urandom_range(1, 3);
            gap  = $urandom_range(0, 22);
            for (int i = 0; i < per * reps + gap; i++) begin
                sig_b = (i < per * reps) ? ((i % per) >= per - hi) : 1'b0;
                tick();
                n_checks++;
                if ({mv_b, per_b, hi_b, lk_b, ev_b, ov_b} !== exp_b()) begin
                    n_fail++; $display("FAIL rand_b k=%0d: got %h want %h", k, {mv_b, per_b, hi_b, lk_b, ev_b, ov_b}, exp_b());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_release_high();
        test_div2();
        test_div6_to_div4();
        test_non50();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
